ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

- Carries the decoded control bundles (`id_ex`, `id_m`, `id_wb`) from the decode stage through the EX, MEM and WB pipeline registers of the scpu datapath.
- Resolves conditional branches in EX and detects load-use hazards, generating stall and flush.
- Generates the EX-stage operand forwarding selects.
- It is the consumer end of the decode control interface: every bit the decoder emits is registered, interpreted and retired here.

## Interface
Parameters:
- `REG_W`, default 5: register-index width.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `id_ex`  in  5  {alu_src_b, alu_op[3:0]} from decode.
- `id_m`  in  3  {branch, b_type, mem_write}; b_type=1 means beq, 0 means bne.
- `id_wb`  in  3  {reg_write, mem_to_reg[1:0]}; mem_to_reg 2'b11 marks a load.
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_W each  source and destination indices of the ID instruction.
- `ex_zero`  in  1  ALU zero flag of the instruction currently in EX.
- `ex_alu_src_b`  out  1  registered.
- `ex_alu_op`  out  4  registered.
- `mem_mem_write`  out  1  registered.
- `wb_reg_write`  out  1  registered.
- `wb_mem_to_reg`  out  2  registered.
- `ex_rd`, `mem_rd`, `wb_rd`  out  REG_W each  registered destination index per stage.
- `forward_a`, `forward_b`  out  2  combinational: 00 = register file, 10 = MEM result, 01 = WB result.
- `stall`  out  1  combinational: hold PC and IF/ID.
- `flush`  out  1  combinational: squash IF/ID.
- `pc_src`  out  1  combinational: select branch target.

## Operation
Pipeline registers:
- EX holds id_ex, id_m, id_wb, rs1, rs2 and rd.
- MEM holds the m and wb groups plus rd.
- WB holds the wb group plus rd.
- A bubble is all control bits 0 and all indices 0.

Branch resolution:
- `pc_src = ex_branch & (ex_b_type ? ex_zero : ~ex_zero)`.
- `flush = pc_src`.

Load-use hazard:
- `stall = ex_reg_write & (ex_mem_to_reg==2'b11) & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2)`.
- `stall` is forced to 0 whenever `flush`=1.

Register update at each posedge:
- EX loads a bubble if `flush` or `stall` is 1; otherwise it loads the ID inputs.
- MEM always loads the EX contents.
- WB always loads the MEM contents.
- A bubbled instruction never writes memory or the register file.

Forwarding for operand A (operand B is identical, using ex_rs2):
- 10 if `mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1`.
- Otherwise 01 if `wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1`.
- Otherwise 00.
- MEM has priority over WB.

Other rules:
- Index comparisons are full REG_W-bit equality.
- x0 is never forwarded and never causes a stall.
- There is no state machine beyond the three register stages.

## Timing
Latency:
- An ID bundle presented in cycle n appears on ex_* in n+1, mem_* in n+2 and wb_* in n+3, absent stall or flush.

Stall:
- An instruction held by `stall` re-presents its ID inputs. It enters EX one cycle later, with exactly one bubble inserted.

Flush:
- `pc_src` and `flush` are valid in the same cycle the branch occupies EX.
- The next EX content is a bubble; the branch itself proceeds to MEM.

Combinational outputs:
- forward_*, stall, flush and pc_src depend only on the current register state, `ex_zero` and the id_rs indices.
- None of them depends on id_ex, id_m or id_wb.

Reset:
- While `rst` is high, all registered outputs and internal stage registers are 0 immediately, independent of clk.
- Combinational outputs therefore evaluate to 0.
- Deasserting `rst` mid-stream discards every in-flight instruction; the first post-reset ID bundle is captured on the first posedge with `rst`=0.

Simultaneous events: flush beats stall; MEM forwarding beats WB forwarding.

## Test plan
- Straight-line flow:
  - Stimulus: ADDI bundle (id_ex=5'b10000, id_wb=3'b100, rd=5) in cycle 0.
  - Response: ex_alu_src_b=1 in cycle 1; wb_reg_write=1, wb_rd=5 in cycle 3.
- Load-use stall:
  - Stimulus: load (id_wb=3'b111, rd=3) followed by R-type with rs1=3.
  - Response: stall=1 for exactly one cycle; EX holds a bubble; the R-type reaches EX one cycle later with forward_a=01.
- Branch flush:
  - Stimulus: beq (id_m=3'b110) with ex_zero=1 while in EX.
  - Response: pc_src=flush=1 that cycle; next EX is a bubble.
  - Repeat with ex_zero=0: pc_src=0.
  - bne (id_m=3'b100) inverts both outcomes.
- Forwarding priority:
  - Stimulus: three consecutive writes to x7, then a read of x7 in EX while MEM and WB both target x7.
  - Response: forward_a=10.
  - Any target of x0: forward_a=00.
- Asynchronous reset:
  - Stimulus: assert rst mid-cycle with a store in MEM.
  - Response: mem_mem_write=0 immediately.
  - After release, the first new bundle appears on ex_* after one posedge.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
//==============================================================================
// Module   : ctrl_pipe_if
// Brief    : Decode-to-pipeline control bundle interface for ctrl_pipe.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface ctrl_pipe_if #(
    parameter int REG_W = 5
);
    logic [4:0]       id_ex;
    logic [2:0]       id_m;
    logic [2:0]       id_wb;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] id_rd;
    logic             ex_zero;

    logic             ex_alu_src_b;
    logic [3:0]       ex_alu_op;
    logic             mem_mem_write;
    logic             wb_reg_write;
    logic [1:0]       wb_mem_to_reg;
    logic [REG_W-1:0] ex_rd;
    logic [REG_W-1:0] mem_rd;
    logic [REG_W-1:0] wb_rd;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             stall;
    logic             flush;
    logic             pc_src;

    modport master (
        output id_ex, id_m, id_wb, id_rs1, id_rs2, id_rd, ex_zero,
        input  ex_alu_src_b, ex_alu_op, mem_mem_write, wb_reg_write, wb_mem_to_reg,
               ex_rd, mem_rd, wb_rd, forward_a, forward_b, stall, flush, pc_src
    );

    modport slave (
        input  id_ex, id_m, id_wb, id_rs1, id_rs2, id_rd, ex_zero,
        output ex_alu_src_b, ex_alu_op, mem_mem_write, wb_reg_write, wb_mem_to_reg,
               ex_rd, mem_rd, wb_rd, forward_a, forward_b, stall, flush, pc_src
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_pipe.sv
//==============================================================================
// Module   : ctrl_pipe
// Brief    : EX/MEM/WB control pipeline with branch flush, load-use stall and
//            operand forwarding selects.
// Revision : 1.0
//==============================================================================
`default_nettype none

module ctrl_pipe #(
    parameter int REG_W = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ctrl_pipe_if.slave  bus
);
    localparam logic [1:0] c_MEM_TO_REG_LOAD = 2'b11;
    localparam logic [1:0] c_FWD_RF          = 2'b00;
    localparam logic [1:0] c_FWD_MEM         = 2'b10;
    localparam logic [1:0] c_FWD_WB          = 2'b01;

    // EX stage
    logic             r_ex_alu_src_b;
    logic [3:0]       r_ex_alu_op;
    logic             r_ex_branch;
    logic             r_ex_b_type;
    logic             r_ex_mem_write;
    logic             r_ex_reg_write;
    logic [1:0]       r_ex_mem_to_reg;
    logic [REG_W-1:0] r_ex_rs1;
    logic [REG_W-1:0] r_ex_rs2;
    logic [REG_W-1:0] r_ex_rd;
    // MEM stage
    logic             r_mem_mem_write;
    logic             r_mem_reg_write;
    logic [1:0]       r_mem_mem_to_reg;
    logic [REG_W-1:0] r_mem_rd;
    // WB stage
    logic             r_wb_reg_write;
    logic [1:0]       r_wb_mem_to_reg;
    logic [REG_W-1:0] r_wb_rd;

    logic w_pc_src;
    logic w_load_use;
    logic w_stall;
    logic w_bubble;

    assign w_pc_src   = r_ex_branch & (r_ex_b_type ? bus.ex_zero : ~bus.ex_zero);
    assign w_load_use = r_ex_reg_write & (r_ex_mem_to_reg == c_MEM_TO_REG_LOAD) &
                        (r_ex_rd != '0) &
                        ((r_ex_rd == bus.id_rs1) | (r_ex_rd == bus.id_rs2));
    // A taken branch squashes the ID instruction, so its hazard is moot.
    assign w_stall    = w_load_use & ~w_pc_src;
    assign w_bubble   = w_pc_src | w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_alu_src_b   <= 1'b0;
            r_ex_alu_op      <= '0;
            r_ex_branch      <= 1'b0;
            r_ex_b_type      <= 1'b0;
            r_ex_mem_write   <= 1'b0;
            r_ex_reg_write   <= 1'b0;
            r_ex_mem_to_reg  <= '0;
            r_ex_rs1         <= '0;
            r_ex_rs2         <= '0;
            r_ex_rd          <= '0;
            r_mem_mem_write  <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= '0;
            r_mem_rd         <= '0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= '0;
            r_wb_rd          <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_alu_src_b  <= 1'b0;
                r_ex_alu_op     <= '0;
                r_ex_branch     <= 1'b0;
                r_ex_b_type     <= 1'b0;
                r_ex_mem_write  <= 1'b0;
                r_ex_reg_write  <= 1'b0;
                r_ex_mem_to_reg <= '0;
                r_ex_rs1        <= '0;
                r_ex_rs2        <= '0;
                r_ex_rd         <= '0;
            end else begin
                {r_ex_alu_src_b, r_ex_alu_op}                 <= bus.id_ex;
                {r_ex_branch, r_ex_b_type, r_ex_mem_write}    <= bus.id_m;
                {r_ex_reg_write, r_ex_mem_to_reg}             <= bus.id_wb;
                r_ex_rs1                                      <= bus.id_rs1;
                r_ex_rs2                                      <= bus.id_rs2;
                r_ex_rd                                       <= bus.id_rd;
            end
            r_mem_mem_write  <= r_ex_mem_write;
            r_mem_reg_write  <= r_ex_reg_write;
            r_mem_mem_to_reg <= r_ex_mem_to_reg;
            r_mem_rd         <= r_ex_rd;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_rd          <= r_mem_rd;
        end
    end

    always_comb begin
        bus.forward_a = c_FWD_RF;
        bus.forward_b = c_FWD_RF;
        // MEM is checked last so it overrides an older WB match.
        if (r_wb_reg_write && (r_wb_rd != '0) && (r_wb_rd == r_ex_rs1))
            bus.forward_a = c_FWD_WB;
        if (r_mem_reg_write && (r_mem_rd != '0) && (r_mem_rd == r_ex_rs1))
            bus.forward_a = c_FWD_MEM;
        if (r_wb_reg_write && (r_wb_rd != '0) && (r_wb_rd == r_ex_rs2))
            bus.forward_b = c_FWD_WB;
        if (r_mem_reg_write && (r_mem_rd != '0) && (r_mem_rd == r_ex_rs2))
            bus.forward_b = c_FWD_MEM;
    end

    assign bus.ex_alu_src_b  = r_ex_alu_src_b;
    assign bus.ex_alu_op     = r_ex_alu_op;
    assign bus.mem_mem_write = r_mem_mem_write;
    assign bus.wb_reg_write  = r_wb_reg_write;
    assign bus.wb_mem_to_reg = r_wb_mem_to_reg;
    assign bus.ex_rd         = r_ex_rd;
    assign bus.mem_rd        = r_mem_rd;
    assign bus.wb_rd         = r_wb_rd;
    assign bus.stall         = w_stall;
    assign bus.flush         = w_pc_src;
    assign bus.pc_src        = w_pc_src;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
//==============================================================================
// Module   : tb_ctrl_pipe
// Brief    : Directed self-checking bench for ctrl_pipe.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_ctrl_pipe;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ctrl_pipe_if #(.REG_W(5)) bus ();

    ctrl_pipe #(.REG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] ex, input logic [2:0] m, input logic [2:0] wb,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus.id_ex  = ex;
        bus.id_m   = m;
        bus.id_wb  = wb;
        bus.id_rs1 = rs1;
        bus.id_rs2 = rs2;
        bus.id_rd  = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(5'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        bus.ex_zero = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.ex_zero = 1'b0;
        set_id(5'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0);

        // Reset state before any clock edge
        #3;
        check("rst_ex_alu_src_b", {7'd0, bus.ex_alu_src_b}, 8'd0);
        check("rst_mem_mem_write", {7'd0, bus.mem_mem_write}, 8'd0);
        check("rst_wb_reg_write", {7'd0, bus.wb_reg_write}, 8'd0);
        check("rst_wb_rd", {3'd0, bus.wb_rd}, 8'd0);
        check("rst_forward_a", {6'd0, bus.forward_a}, 8'd0);
        check("rst_pc_src", {7'd0, bus.pc_src}, 8'd0);
        #12;
        rst = 1'b0;

        // Straight-line ADDI x5
        set_id(5'b10000, 3'b000, 3'b100, 5'd0, 5'd0, 5'd5);
        tick();
        check("addi_ex_alu_src_b", {7'd0, bus.ex_alu_src_b}, 8'd1);
        check("addi_ex_rd", {3'd0, bus.ex_rd}, 8'd5);
        set_id(5'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        tick();
        check("addi_mem_rd", {3'd0, bus.mem_rd}, 8'd5);
        check("addi_ex_after_nop", {7'd0, bus.ex_alu_src_b}, 8'd0);
        tick();
        check("addi_wb_reg_write", {7'd0, bus.wb_reg_write}, 8'd1);
        check("addi_wb_rd", {3'd0, bus.wb_rd}, 8'd5);
        check("addi_wb_mem_to_reg", {6'd0, bus.wb_mem_to_reg}, 8'd0);
        drain();

        // Load x3 followed by R-type reading x3
        set_id(5'd0, 3'b000, 3'b111, 5'd1, 5'd0, 5'd3);
        tick();
        set_id(5'b00010, 3'b000, 3'b100, 5'd3, 5'd4, 5'd6);
        #1;
        check("lu_stall", {7'd0, bus.stall}, 8'd1);
        check("lu_flush", {7'd0, bus.flush}, 8'd0);
        tick();
        check("lu_bubble_ex_rd", {3'd0, bus.ex_rd}, 8'd0);
        check("lu_bubble_ex_alu_op", {4'd0, bus.ex_alu_op}, 8'd0);
        check("lu_stall_released", {7'd0, bus.stall}, 8'd0);
        check("lu_mem_rd", {3'd0, bus.mem_rd}, 8'd3);
        tick();
        check("lu_rtype_ex_rd", {3'd0, bus.ex_rd}, 8'd6);
        check("lu_rtype_ex_alu_op", {4'd0, bus.ex_alu_op}, 8'd2);
        check("lu_wb_mem_to_reg", {6'd0, bus.wb_mem_to_reg}, 8'd3);
        check("lu_forward_a", {6'd0, bus.forward_a}, 8'b01);
        check("lu_forward_b", {6'd0, bus.forward_b}, 8'b00);
        check("lu_no_restall", {7'd0, bus.stall}, 8'd0);
        drain();

        // Load to x0 never stalls
        set_id(5'd0, 3'b000, 3'b111, 5'd0, 5'd0, 5'd0);
        tick();
        set_id(5'd0, 3'b000, 3'b100, 5'd0, 5'd0, 5'd1);
        #1;
        check("x0_load_no_stall", {7'd0, bus.stall}, 8'd0);
        drain();

        // Taken beq that is also a load-use source: flush wins
        set_id(5'd0, 3'b110, 3'b111, 5'd1, 5'd2, 5'd3);
        tick();
        set_id(5'b10000, 3'b000, 3'b100, 5'd3, 5'd0, 5'd9);
        bus.ex_zero = 1'b1;
        #1;
        check("beq_taken_pc_src", {7'd0, bus.pc_src}, 8'd1);
        check("beq_taken_flush", {7'd0, bus.flush}, 8'd1);
        check("flush_beats_stall", {7'd0, bus.stall}, 8'd0);
        tick();
        check("beq_bubble_ex_rd", {3'd0, bus.ex_rd}, 8'd0);
        check("beq_bubble_alu_src_b", {7'd0, bus.ex_alu_src_b}, 8'd0);
        check("beq_to_mem_rd", {3'd0, bus.mem_rd}, 8'd3);
        bus.ex_zero = 1'b0;

        // Not-taken beq
        set_id(5'd0, 3'b110, 3'b000, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(5'b10000, 3'b000, 3'b100, 5'd0, 5'd0, 5'd9);
        #1;
        check("beq_nt_pc_src", {7'd0, bus.pc_src}, 8'd0);
        check("beq_nt_flush", {7'd0, bus.flush}, 8'd0);
        tick();
        check("beq_nt_next_ex_rd", {3'd0, bus.ex_rd}, 8'd9);

        // bne inverts the outcome
        set_id(5'd0, 3'b100, 3'b000, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(5'b10000, 3'b000, 3'b100, 5'd0, 5'd0, 5'd9);
        bus.ex_zero = 1'b1;
        #1;
        check("bne_zero_pc_src", {7'd0, bus.pc_src}, 8'd0);
        bus.ex_zero = 1'b0;
        #1;
        check("bne_nz_pc_src", {7'd0, bus.pc_src}, 8'd1);
        check("bne_nz_flush", {7'd0, bus.flush}, 8'd1);
        tick();
        check("bne_bubble_ex_rd", {3'd0, bus.ex_rd}, 8'd0);
        drain();

        // Three writes to x7 then a read: MEM beats WB
        set_id(5'd0, 3'b000, 3'b100, 5'd0, 5'd0, 5'd7);
        repeat (3) tick();
        set_id(5'd0, 3'b000, 3'b100, 5'd7, 5'd7, 5'd8);
        tick();
        check("fwd_prio_a", {6'd0, bus.forward_a}, 8'b10);
        check("fwd_prio_b", {6'd0, bus.forward_b}, 8'b10);
        drain();

        // WB-only forwarding on operand B
        set_id(5'd0, 3'b000, 3'b100, 5'd0, 5'd0, 5'd7);
        tick();
        set_id(5'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        tick();
        set_id(5'd0, 3'b000, 3'b100, 5'd0, 5'd7, 5'd8);
        tick();
        check("fwd_wb_b", {6'd0, bus.forward_b}, 8'b01);
        check("fwd_wb_a_none", {6'd0, bus.forward_a}, 8'b00);
        drain();

        // Writes to x0 are never forwarded
        set_id(5'd0, 3'b000, 3'b100, 5'd0, 5'd0, 5'd0);
        repeat (2) tick();
        set_id(5'd0, 3'b000, 3'b100, 5'd0, 5'd0, 5'd2);
        tick();
        check("fwd_x0_a", {6'd0, bus.forward_a}, 8'b00);
        check("fwd_x0_b", {6'd0, bus.forward_b}, 8'b00);
        drain();

        // Asynchronous reset with a store in MEM
        set_id(5'd0, 3'b001, 3'b000, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(5'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        tick();
        check("store_mem_write", {7'd0, bus.mem_mem_write}, 8'd1);
        #4;
        rst = 1'b1;
        #1;
        check("arst_mem_mem_write", {7'd0, bus.mem_mem_write}, 8'd0);
        set_id(5'b10000, 3'b000, 3'b100, 5'd0, 5'd0, 5'd5);
        #2;
        rst = 1'b0;
        #1;
        check("arst_hold_ex_rd", {3'd0, bus.ex_rd}, 8'd0);
        tick();
        check("post_rst_ex_alu_src_b", {7'd0, bus.ex_alu_src_b}, 8'd1);
        check("post_rst_ex_rd", {3'd0, bus.ex_rd}, 8'd5);
        check("post_rst_store_gone", {7'd0, bus.mem_mem_write}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
